zombie_game_ctrl: RTL
=====================

// Module: zombie_game_ctrl
// PURPOSE
//  Core game-play controller for PunchZombi. Sits directly downstream of the clock divider.
//  - Converts the divider's slow square wave into a one-clk game tick.
//  - Spawns zombies pseudo-randomly into NUM_HOLES holes and times their escape.
//  - Scores player punches; tracks lives and the game timer.
//  - Outputs drive the LED/7-seg display logic.
// PARAMETERS
//  NUM_HOLES    8        number of holes/punch buttons (power of 2, 2..16)
//  SCORE_W      8        score width; score saturates at 2**SCORE_W-1
//  LIVES_INIT   3        lives loaded at game start (1..3)
//  UP_TICKS     6        ticks a zombie stays up before escaping (>=1)
//  SPAWN_TICKS  4        ticks between spawn attempts (>=1)
//  GAME_TICKS   200      game duration in ticks (1..255)
//  LFSR_SEED    16'hACE1 LFSR reset value (non-zero)
// PORTS
//  clk        in   1          system clock
//  rst        in   1          reset, asynchronous, active-high
//  clk_div    in   1          slow square wave from clock divider, generated in clk domain
//  start      in   1          start/restart button, debounced level
//  punch      in   NUM_HOLES  punch buttons, debounced levels, one per hole
//  zombie     out  NUM_HOLES  1 = zombie up in hole i
//  score      out  SCORE_W    hits this game
//  lives      out  2          remaining lives
//  time_left  out  8          remaining game ticks
//  state      out  2          0=IDLE 1=PLAY 2=OVER
//  game_over  out  1          high while in OVER
//  hit_pulse  out  1          one-clk pulse on any successful hit
//  miss_pulse out  1          one-clk pulse on any escape
// BEHAVIOUR
//  Reset value of all outputs is 0; state=IDLE. clk_div_q, start_q and punch_q also reset to 0.
//  Reset mid-game aborts immediately (async); no state is retained.
//  tick = clk_div & ~clk_div_q: one clk pulse per clk_div rise. No synchronizer (same domain).
//  Edge detection: start_rise and punch_rise[i] use the same scheme (level & ~registered level).
//  Timing: all effects land on the clk edge where the rise is sampled. Outputs are registered.
//  LFSR: 16-bit Galois, taps 0xB400, advances every clk in all states; not reloaded at game start.
//  IDLE: zombie=0. On start_rise -> PLAY; load:
//    score=0, lives=LIVES_INIT, time_left=GAME_TICKS, spawn_cnt=0, all age counters=0.
//  PLAY, on tick:
//    time_left -= 1.
//    Each up zombie's age -= 1. An age of 1 at the tick means escape:
//      bit clears, lives -= 1 per escape (saturate 0), miss_pulse.
//    spawn_cnt increments; at SPAWN_TICKS-1 it wraps to 0 and attempts a spawn.
//      Target hole h = lfsr[log2(NUM_HOLES)-1:0].
//      If hole h is up, or escaped this same tick -> no spawn, no retry.
//      Otherwise set zombie[h] and age[h]=UP_TICKS.
//  PLAY, any cycle:
//    punch_rise[i] with zombie[i]=1 -> clear bit, score += 1 (saturate), hit_pulse.
//    Multiple hits in one cycle add their popcount.
//    punch on an empty hole is ignored. start_rise is ignored in PLAY.
//  Simultaneous events:
//    punch_rise and escape on the same hole in the same cycle -> hit wins, no life lost.
//    punch_rise on hole h on a spawn tick for h -> spawn happens; punch is ignored.
//  PLAY -> OVER on the edge where lives becomes 0 or time_left becomes 0.
//    zombie clears on the same edge; score is held.
//  OVER: game_over=1, zombie=0, ticks ignored. start_rise -> PLAY with a fresh load, as from IDLE.
// STRUCTURE
//  Package zombie_game_pkg holds:
//    - state encoding constants IDLE/PLAY/OVER
//    - LFSR_TAPS = 16'hB400
//    - the clog2 helper
//  Sub-module lfsr16 (clk, rst, seed param, q[15:0]) is the free-running Galois LFSR.
//  Per-hole age counters are written as a generate loop inside this block.
// TESTING (NUM_HOLES=8, UP_TICKS=6, SPAWN_TICKS=4, LIVES_INIT=3 unless noted)
//  1 Reset, toggle clk_div 10 times, no start
//      -> state=0, zombie=0, score=0, lives=0, no pulses.
//  2 start rise, 4 ticks -> exactly one zombie bit at lfsr[2:0] index.
//    Then punch that hole -> bit clears, score=1, hit_pulse for 1 clk.
//  3 Zombie left alone for 6 ticks after spawn
//      -> bit clears on 6th tick, lives 3->2, miss_pulse for 1 clk.
//  4 Three consecutive escapes -> lives=0, state=2, game_over=1, zombie=0.
//    Then start rise -> state=1, score=0, lives=3, time_left=200.
//  5 GAME_TICKS=10, punch every zombie -> OVER exactly on 10th tick, time_left=0, score held.
//    SCORE_W=2 run: 5 hits -> score stays 3.
//  6 Punch rise on the hole's escape tick -> score+1, lives unchanged.
//    Then assert rst mid-PLAY -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/zombie_game_pkg.sv
// Shared definitions for the PunchZombi game-play controller.
// Holds the FSM state encoding, the LFSR tap mask and a constant clog2 helper.
// No logic, no latency, no flow control.
package zombie_game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Ceiling log2 for sizing counters from parameters.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used to pick spawn holes.
// Latency: advances one step every clk, in every game state; new value visible the next cycle.
// Backpressure: none, it never stalls.
// Ports: clk, rst (async, active-high, loads SEED), o_q = current LFSR state.
module lfsr16
   import zombie_game_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] o_q
);

   logic [15:0] r_q;

   // Right-shifting Galois form: the bit shifted out folds the tap mask back in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_q <= SEED;
      else     r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_TAPS : 16'h0000);
   end

   assign o_q = r_q;

endmodule

// File: rtl/zombie_game_ctrl.sv
// Game-play controller: turns the divider square wave into game ticks, spawns/escapes zombies,
// scores punches and tracks lives/time. Latency: every effect is registered on the clk edge that
// samples the input rise. Backpressure: none; inputs are levels, outputs are always valid.
// Ports: clk, rst (async high); i_clk_div slow square wave; i_start start button; i_punch per hole;
//        o_zombie up mask; o_score; o_lives; o_time_left; o_state (0 idle,1 play,2 over);
//        o_game_over; o_hit_pulse / o_miss_pulse one-clk event strobes.
module zombie_game_ctrl
   import zombie_game_pkg::*;
#(
   parameter int          NUM_HOLES   = 8,
   parameter int          SCORE_W     = 8,
   parameter int          LIVES_INIT  = 3,
   parameter int          UP_TICKS    = 6,
   parameter int          SPAWN_TICKS = 4,
   parameter int          GAME_TICKS  = 200,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clk_div,
   input  logic                 i_start,
   input  logic [NUM_HOLES-1:0] i_punch,
   output logic [NUM_HOLES-1:0] o_zombie,
   output logic [SCORE_W-1:0]   o_score,
   output logic [1:0]           o_lives,
   output logic [7:0]           o_time_left,
   output logic [1:0]           o_state,
   output logic                 o_game_over,
   output logic                 o_hit_pulse,
   output logic                 o_miss_pulse
);

   localparam int H_W   = clog2(NUM_HOLES);
   localparam int AGE_W = clog2(UP_TICKS + 1);
   localparam int SP_W  = clog2(SPAWN_TICKS + 1);
   localparam int CNT_W = clog2(NUM_HOLES + 1);
   localparam int SUM_W = SCORE_W + CNT_W;
   localparam int CMP_W = CNT_W + 2;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   state_t               r_state, w_state_nxt;
   logic                 r_clk_div_q, r_start_q;
   logic [NUM_HOLES-1:0] r_punch_q;
   logic [NUM_HOLES-1:0] r_zombie;
   logic [SCORE_W-1:0]   r_score;
   logic [1:0]           r_lives;
   logic [7:0]           r_time;
   logic [SP_W-1:0]      r_spawn_cnt;
   logic                 r_hit_pulse, r_miss_pulse;

   logic                 w_tick, w_start_rise, w_play, w_load, w_to_over;
   logic [NUM_HOLES-1:0] w_punch_rise, w_hit, w_esc, w_miss, w_spawn, w_zombie_nxt;
   logic [15:0]          w_lfsr;
   logic [H_W-1:0]       w_hole;
   logic                 w_lfsr_unused;
   logic                 w_spawn_try, w_spawn_ok;
   logic [CNT_W-1:0]     w_hit_cnt, w_miss_cnt;
   logic [SUM_W-1:0]     w_score_sum;
   logic [SCORE_W-1:0]   w_score_nxt;
   logic [1:0]           w_lives_nxt;
   logic [7:0]           w_time_nxt;
   logic [SP_W-1:0]      w_spawn_cnt_nxt;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .o_q(w_lfsr));

   assign w_hole        = w_lfsr[H_W-1:0];
   assign w_lfsr_unused = ^w_lfsr[15:H_W];

   // Divider output is already in the clk domain, so a plain edge detect is enough.
   assign w_tick       = i_clk_div & ~r_clk_div_q;
   assign w_start_rise = i_start & ~r_start_q;
   assign w_punch_rise = i_punch & ~r_punch_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_div_q <= 1'b0;
         r_start_q   <= 1'b0;
         r_punch_q   <= '0;
      end else begin
         r_clk_div_q <= i_clk_div;
         r_start_q   <= i_start;
         r_punch_q   <= i_punch;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_OVER: if (w_start_rise) w_state_nxt = ST_PLAY;
         ST_PLAY:          if (w_to_over)    w_state_nxt = ST_OVER;
         default:          w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs / decodes ----------------
   always_comb begin
      w_play      = 1'b0;
      w_load      = 1'b0;
      o_game_over = 1'b0;
      case (r_state)
         ST_IDLE: w_load = w_start_rise;
         ST_PLAY: w_play = 1'b1;
         ST_OVER: begin
            w_load      = w_start_rise;
            o_game_over = 1'b1;
         end
         default: ;
      endcase
   end

   // Spawn only into a hole that was empty before this edge; an escaping zombie
   // was up, so this also rules out respawning into the hole it just left.
   assign w_spawn_try = w_play & w_tick & (r_spawn_cnt == SP_W'(SPAWN_TICKS - 1));
   assign w_spawn_ok  = w_spawn_try & ~r_zombie[w_hole];

   for (genvar i = 0; i < NUM_HOLES; i++) begin : g_hole
      logic [AGE_W-1:0] r_age;

      assign w_hit[i]   = w_play & w_punch_rise[i] & r_zombie[i];
      assign w_esc[i]   = w_play & w_tick & r_zombie[i] & (r_age == AGE_W'(1));
      // A punch on the escape tick wins: no life is lost.
      assign w_miss[i]  = w_esc[i] & ~w_hit[i];
      assign w_spawn[i] = w_spawn_ok & (w_hole == H_W'(i));

      always_ff @(posedge clk or posedge rst) begin
         if (rst)                                   r_age <= '0;
         else if (w_load)                           r_age <= '0;
         else if (w_spawn[i])                       r_age <= AGE_W'(UP_TICKS);
         else if (w_play && w_tick && r_zombie[i])  r_age <= r_age - AGE_W'(1);
      end
   end

   always_comb begin
      w_hit_cnt  = '0;
      w_miss_cnt = '0;
      for (int k = 0; k < NUM_HOLES; k++) begin
         w_hit_cnt  = w_hit_cnt  + CNT_W'(w_hit[k]);
         w_miss_cnt = w_miss_cnt + CNT_W'(w_miss[k]);
      end
   end

   assign w_score_sum = SUM_W'(r_score) + SUM_W'(w_hit_cnt);
   assign w_score_nxt = (w_score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : w_score_sum[SCORE_W-1:0];
   assign w_lives_nxt = (CMP_W'(w_miss_cnt) >= CMP_W'(r_lives)) ? 2'd0 : r_lives - w_miss_cnt[1:0];
   assign w_time_nxt  = w_tick ? r_time - 8'd1 : r_time;
   assign w_to_over   = w_play & ((w_lives_nxt == 2'd0) | (w_time_nxt == 8'd0));
   assign w_zombie_nxt = (r_zombie & ~w_hit & ~w_esc) | w_spawn;
   assign w_spawn_cnt_nxt = !w_tick ? r_spawn_cnt :
                            (r_spawn_cnt == SP_W'(SPAWN_TICKS - 1)) ? '0 : r_spawn_cnt + SP_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_zombie     <= '0;
         r_score      <= '0;
         r_lives      <= '0;
         r_time       <= '0;
         r_spawn_cnt  <= '0;
         r_hit_pulse  <= 1'b0;
         r_miss_pulse <= 1'b0;
      end else begin
         r_hit_pulse  <= 1'b0;
         r_miss_pulse <= 1'b0;
         if (w_load) begin
            r_zombie    <= '0;
            r_score     <= '0;
            r_lives     <= 2'(LIVES_INIT);
            r_time      <= 8'(GAME_TICKS);
            r_spawn_cnt <= '0;
         end else if (w_play) begin
            r_zombie     <= w_to_over ? '0 : w_zombie_nxt;
            r_score      <= w_score_nxt;
            r_lives      <= w_lives_nxt;
            r_time       <= w_time_nxt;
            r_spawn_cnt  <= w_spawn_cnt_nxt;
            r_hit_pulse  <= |w_hit;
            r_miss_pulse <= |w_miss;
         end
      end
   end

   assign o_zombie     = r_zombie;
   assign o_score      = r_score;
   assign o_lives      = r_lives;
   assign o_time_left  = r_time;
   assign o_state      = r_state;
   assign o_hit_pulse  = r_hit_pulse;
   assign o_miss_pulse = r_miss_pulse;

endmodule
